// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus widths, response owner
// encoding and the bundled request payload.
package dmem_arbiter_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DMA  = 2'd2
  } mem_owner_type;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_type;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// Handshake: a request transfers in a cycle where req_valid && req_ready; a
// pending request holds its payload stable until then; read data returns with
// rsp_valid exactly one cycle after the transfer; writes return nothing.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req_valid;
  logic              dma_req_ready;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_rsp_valid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req_valid, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rdata,
    output dma_req_ready, dma_rsp_valid, dma_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output dma_req_valid, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rdata,
    input  dma_req_ready, dma_rsp_valid, dma_rdata,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_aging.sv
// DMA starvation guard: counts cycles a DMA request is blocked and forces a
// DMA grant once the count reaches DMA_MAX_WAIT.
module dmem_arb_aging
  import dmem_arbiter_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_dma_req_valid,
  input  logic i_grant_dma,
  output logic o_force_dma
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(DMA_MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (!i_dma_req_valid || i_grant_dma) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_force_dma = i_dma_req_valid && (r_wait_cnt >= MAX_WAIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority (CPU first) arbiter sharing the single-port data memory with
// a loader/DMA port. Build with DMEM_ARB_AGING_EN to bound DMA starvation.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output mem_owner_type  o_dbg_rsp_owner
);

  generate
    if (DMA_MAX_WAIT < 1 || DMA_MAX_WAIT > 255) begin : g_bad_max_wait
      $error("dmem_arbiter: DMA_MAX_WAIT must be within 1..255");
    end
  endgenerate

  mem_req_type       w_cpu_req;
  mem_req_type       w_dma_req;
  mem_req_type       w_mem_req;
  logic              w_force_dma;
  logic              w_grant_cpu;
  logic              w_grant_dma;
  mem_owner_type     r_rsp_owner;
  mem_owner_type     w_rsp_owner_next;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  assign w_cpu_req = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign w_dma_req = '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};

`ifdef DMEM_ARB_AGING_EN
  dmem_arb_aging #(.DMA_MAX_WAIT(DMA_MAX_WAIT)) u_aging (
    .clk             (clk),
    .reset           (reset),
    .i_dma_req_valid (bus.dma_req_valid),
    .i_grant_dma     (w_grant_dma),
    .o_force_dma     (w_force_dma)
  );
`else
  assign w_force_dma = 1'b0;
`endif

  assign bus.cpu_req_ready = !reset && !w_force_dma;
  assign bus.dma_req_ready = !reset && (!bus.cpu_req_valid || w_force_dma);
  assign w_grant_cpu       = bus.cpu_req_valid && bus.cpu_req_ready;
  assign w_grant_dma       = bus.dma_req_valid && bus.dma_req_ready;

  // Idle cycles keep the last address so the memory address bus stays quiet.
  always_comb begin
    w_mem_req = '{we: 1'b0, addr: r_addr_hold, wdata: '0};
    if (reset) begin
      w_mem_req.addr = '0;
    end else if (w_grant_cpu) begin
      w_mem_req = w_cpu_req;
    end else if (w_grant_dma) begin
      w_mem_req = w_dma_req;
    end
  end

  assign bus.mem_we    = w_mem_req.we;
  assign bus.mem_addr  = w_mem_req.addr;
  assign bus.mem_wdata = w_mem_req.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_owner <= OWNER_NONE;
    end else begin
      r_rsp_owner <= w_rsp_owner_next;
    end
  end

  always_comb begin
    w_rsp_owner_next = OWNER_NONE;
    if (w_grant_cpu && !w_cpu_req.we) begin
      w_rsp_owner_next = OWNER_CPU;
    end else if (w_grant_dma && !w_dma_req.we) begin
      w_rsp_owner_next = OWNER_DMA;
    end
  end

  // Gating with reset drops a read that was in flight when reset arrived.
  always_comb begin
    bus.cpu_rsp_valid = !reset && (r_rsp_owner == OWNER_CPU);
    bus.dma_rsp_valid = !reset && (r_rsp_owner == OWNER_DMA);
    bus.cpu_rdata     = bus.cpu_rsp_valid ? bus.mem_rdata : r_cpu_rdata;
    bus.dma_rdata     = bus.dma_rsp_valid ? bus.mem_rdata : r_dma_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_hold <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_addr_hold <= w_mem_req.addr;
      r_cpu_rdata <= bus.cpu_rdata;
      r_dma_rdata <= bus.dma_rdata;
    end
  end

  assign o_dbg_rsp_owner = r_rsp_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a rule-level model of grants, the memory image and responses.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_AGING_EN
  localparam bit AGING_ON = 1'b1;
`else
  localparam bit AGING_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  mem_owner_type dbg_owner;
  int            n_checks;
  int            n_fail;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DMA_MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .o_dbg_rsp_owner (dbg_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory behind the arbiter (write-first, 1-cycle read) ----
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata          <= bus.mem_wdata;
    end else begin
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] cpu_exp_q[$];
  logic [31:0] dma_exp_q[$];
  logic [31:0] cpu_last, dma_last;
  logic [9:0]  ref_addr_hold;
  int          ref_wait;
  logic        m_force, m_g_cpu, m_g_dma, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_exp;
  logic [1:0]  m_owner;

  always @(negedge clk) begin
    if (reset) begin
      check_eq("rst_cpu_ready", 32'(bus.cpu_req_ready), 32'd0);
      check_eq("rst_dma_ready", 32'(bus.dma_req_ready), 32'd0);
      check_eq("rst_mem_we",    32'(bus.mem_we), 32'd0);
      check_eq("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check_eq("rst_cpu_rsp",   32'(bus.cpu_rsp_valid), 32'd0);
      check_eq("rst_dma_rsp",   32'(bus.dma_rsp_valid), 32'd0);
      cpu_exp_q.delete();
      dma_exp_q.delete();
      cpu_last      = '0;
      dma_last      = '0;
      ref_addr_hold = '0;
      ref_wait      = 0;
    end else begin
      // A DMA blocked for MAX_WAIT cycles overrides the CPU's priority.
      m_force = AGING_ON && bus.dma_req_valid && (ref_wait >= MAX_WAIT);
      m_g_cpu = bus.cpu_req_valid && !m_force;
      m_g_dma = bus.dma_req_valid && !m_g_cpu;
      check_eq("cpu_ready", 32'(bus.cpu_req_ready), 32'(!m_force));
      check_eq("dma_ready", 32'(bus.dma_req_ready), 32'(!bus.cpu_req_valid || m_force));

      m_we = 1'b0; m_addr = ref_addr_hold; m_wdata = '0;
      if (m_g_cpu) begin
        m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
      end else if (m_g_dma) begin
        m_we = bus.dma_we; m_addr = bus.dma_addr; m_wdata = bus.dma_wdata;
      end
      check_eq("mem_we",    32'(bus.mem_we), 32'(m_we));
      check_eq("mem_addr",  32'(bus.mem_addr), 32'(m_addr));
      check_eq("mem_wdata", bus.mem_wdata, m_wdata);
      ref_addr_hold = m_addr;

      m_owner = (cpu_exp_q.size() != 0) ? 2'd1 : (dma_exp_q.size() != 0) ? 2'd2 : 2'd0;
      check_eq("rsp_owner", 32'(dbg_owner), 32'(m_owner));

      check_eq("cpu_rsp_valid", 32'(bus.cpu_rsp_valid), 32'(cpu_exp_q.size() != 0));
      if (cpu_exp_q.size() != 0) cpu_last = cpu_exp_q.pop_front();
      check_eq("cpu_rdata", bus.cpu_rdata, cpu_last);
      check_eq("dma_rsp_valid", 32'(bus.dma_rsp_valid), 32'(dma_exp_q.size() != 0));
      if (dma_exp_q.size() != 0) dma_last = dma_exp_q.pop_front();
      check_eq("dma_rdata", bus.dma_rdata, dma_last);

      if (m_g_cpu || m_g_dma) begin
        if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
        else begin
          m_exp = ref_mem[m_addr[9:2]];
          if (m_g_cpu) cpu_exp_q.push_back(m_exp);
          else         dma_exp_q.push_back(m_exp);
        end
      end

      if (bus.dma_req_valid && !m_g_dma) ref_wait = (ref_wait < 255) ? ref_wait + 1 : 255;
      else                               ref_wait = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    bus.cpu_req_valid = v; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    bus.dma_req_valid = v; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int k;
    bit found;
    bit dma_pend;
    logic [31:0] w;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[1] = 32'h11; ref_mem[1] = 32'h11;
    mem[2] = 32'h22; ref_mem[2] = 32'h22;

    // Reset held with both requesters active.
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 10'h020, 32'h0);
    set_dma(1'b1, 1'b0, 10'h024, 32'h0);
    repeat (3) begin
      sample();
      check_eq("rst_hold_cpu_rdy", 32'(bus.cpu_req_ready), 32'd0);
      next_cycle();
    end
    reset = 1'b0;
    sample();
    check_eq("post_rst_cpu_grant", 32'(bus.cpu_req_ready), 32'd1);
    check_eq("post_rst_dma_block", 32'(bus.dma_req_ready), 32'd0);
    check_eq("post_rst_addr", 32'(bus.mem_addr), 32'h020);
    next_cycle();
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    sample();
    check_eq("post_rst_dma_acc", 32'(bus.dma_req_ready), 32'd1);
    next_cycle();
    set_dma(1'b0, 1'b0, 10'h0, 32'h0);

    // CPU write then read of the same word.
    set_cpu(1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'h010, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    sample();
    check_eq("raw_cpu_valid", 32'(bus.cpu_rsp_valid), 32'd1);
    check_eq("raw_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check_eq("raw_dma_quiet", 32'(bus.dma_rsp_valid), 32'd0);
    next_cycle();

    // Collision: CPU wins, DMA follows one cycle later.
    set_cpu(1'b1, 1'b0, 10'h004, 32'h0);
    set_dma(1'b1, 1'b0, 10'h008, 32'h0);
    sample();
    check_eq("col_dma_blocked", 32'(bus.dma_req_ready), 32'd0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    sample();
    check_eq("col_dma_accept", 32'(bus.dma_req_ready), 32'd1);
    check_eq("col_cpu_rdata", bus.cpu_rdata, 32'h11);
    next_cycle();
    set_dma(1'b0, 1'b0, 10'h0, 32'h0);
    sample();
    check_eq("col_dma_valid", 32'(bus.dma_rsp_valid), 32'd1);
    check_eq("col_dma_rdata", bus.dma_rdata, 32'h22);
    next_cycle();

    // DMA write burst, one accept per cycle, then CPU reads the third word.
    for (int i = 0; i < 4; i++) begin
      set_dma(1'b1, 1'b1, 10'(10'h100 + i * 4), 32'hA000_0000 + 32'(i));
      sample();
      check_eq("burst_accept", 32'(bus.dma_req_ready), 32'd1);
      next_cycle();
    end
    set_dma(1'b0, 1'b0, 10'h0, 32'h0);
    set_cpu(1'b1, 1'b0, 10'h108, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    sample();
    check_eq("burst_readback", bus.cpu_rdata, 32'hA000_0002);
    next_cycle();

    // CPU saturates the port while a DMA read waits.
    set_cpu(1'b1, 1'b0, 10'h000, 32'h0);
    set_dma(1'b1, 1'b0, 10'h008, 32'h0);
    if (AGING_ON) begin
      k = 0;
      found = 1'b0;
      while (!found && k < 100) begin
        sample();
        if (bus.dma_req_ready) begin
          found = 1'b1;
          check_eq("age_latency", 32'(k), 32'(MAX_WAIT));
          check_eq("age_cpu_stall", 32'(bus.cpu_req_ready), 32'd0);
        end
        next_cycle();
        k++;
      end
      if (!found) check_eq("age_timeout", 32'd0, 32'd1);
      set_dma(1'b0, 1'b0, 10'h0, 32'h0);
    end else begin
      acc = 0;
      for (int i = 0; i < 100; i++) begin
        sample();
        if (bus.dma_req_ready) acc++;
        next_cycle();
      end
      check_eq("starve_accepts", 32'(acc), 32'd0);
      set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
      sample();
      check_eq("starve_release", 32'(bus.dma_req_ready), 32'd1);
      next_cycle();
      set_dma(1'b0, 1'b0, 10'h0, 32'h0);
    end
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    next_cycle();

    // Reset right after a granted CPU read drops the response.
    set_cpu(1'b1, 1'b0, 10'h004, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    reset = 1'b1;
    sample();
    check_eq("midrd_rsp_in_rst", 32'(bus.cpu_rsp_valid), 32'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    check_eq("midrd_owner", 32'(dbg_owner), 32'(OWNER_NONE));
    check_eq("midrd_rsp_after", 32'(bus.cpu_rsp_valid), 32'd0);
    next_cycle();

    // Random mixed traffic; the DMA holds its payload until accepted.
    dma_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 15) * 4), $urandom);
      if (!dma_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          dma_pend = 1'b1;
          set_dma(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15) * 4), $urandom);
        end else begin
          set_dma(1'b0, 1'b0, 10'h0, 32'h0);
        end
      end
      sample();
      if (bus.dma_req_valid && bus.dma_req_ready) dma_pend = 1'b0;
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 10'h0, 32'h0);
    set_dma(1'b0, 1'b0, 10'h0, 32'h0);
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1 KiB data memory between two requesters: the pipeline memory stage (CPU) and a loader/DMA port used for program load and debug access.
- Sits between mem_stage and data_memory.
- Arbitrates per cycle, drives the memory port, and routes read data back to the requester that issued the read.
- The CPU has fixed priority; an optional aging guard bounds DMA starvation.

Parameters:
- ADDR_W, 10, byte-address width driven to data_memory.
- DATA_W, 32, data word width.
- DMA_MAX_WAIT, 8, cycles a pending DMA request may be blocked before forced grant (aging feature only; legal range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req_valid  in  1  CPU access request
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rsp_valid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dma_req_valid  in  1  DMA access request
- dma_req_ready  out  1  DMA request accepted this cycle
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  DATA_W  DMA write data
- dma_rsp_valid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- mem_addr  out  ADDR_W  to data_memory byte_address
- mem_we  out  1  to data_memory write_enable
- mem_wdata  out  DATA_W  to data_memory write_data
- mem_rdata  in  DATA_W  from data_memory read_data; valid one cycle after address

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While reset is high: cpu_req_ready = 0, dma_req_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Registered state is cleared: rsp_owner = NONE, *_rsp_valid = 0, *_rdata = 0, wait counter = 0.
  - A read in flight when reset asserts is discarded; no response is produced after reset.
- Grant, combinational within the cycle:
  - grant_cpu = cpu_req_valid && !force_dma.
  - grant_dma = dma_req_valid && (!cpu_req_valid || force_dma).
  - At most one grant per cycle.
  - force_dma = 0 when the aging feature is compiled out.
- Ready:
  - cpu_req_ready = !reset && !force_dma.
  - dma_req_ready = !reset && (!cpu_req_valid || force_dma).
  - A transfer completes when valid && ready are high in the same cycle.
- Memory port:
  - mem_addr, mem_we and mem_wdata are muxed from the granted requester.
  - With no grant: mem_we = 0, mem_addr holds the last value, mem_wdata = 0.
  - Writes commit at the clock edge of the grant cycle.
- Response path:
  - rsp_owner register ∈ {NONE, CPU, DMA}.
  - It is set next cycle to the granted requester if that access was a read; otherwise NONE.
  - In the cycle after a granted read, the owner's *_rsp_valid = 1 and *_rdata = mem_rdata. Read latency is exactly 1 cycle.
  - The non-owner's rsp_valid is 0 and its rdata holds its last value.
  - Writes generate no response.
- Throughput: back-to-back accesses every cycle from either or both requesters.
- Read-after-write to the same address in consecutive cycles returns the new data; data_memory write-first behaviour is required.
- Simultaneous requests: CPU wins unless force_dma; the DMA request stays pending and must hold its payload stable until accepted.

Optional Feature:
- Macro: DMEM_ARB_AGING_EN.
- With it defined:
  - An 8-bit wait counter increments each cycle dma_req_valid && !grant_dma, saturating at 255.
  - It clears on grant_dma or when dma_req_valid = 0.
  - force_dma = (wait_cnt >= DMA_MAX_WAIT) && dma_req_valid.
  - In the forced cycle the CPU is stalled (cpu_req_ready = 0) for exactly one cycle, and the DMA request is served.
- Without it: no counter exists, force_dma = 0, and DMA can starve under continuous CPU traffic.

Decomposition:
- Package common gains:
  - typedef enum logic [1:0] {OWNER_NONE, OWNER_CPU, OWNER_DMA} mem_owner_type;
  - struct mem_req_type {we, addr, wdata}, so that requester ports can be bundled.
- Sub-module dmem_arb_aging holds the saturating wait counter and force_dma compare; it is instantiated only under DMEM_ARB_AGING_EN.
- Everything else lives in one module.

Test Plan:
- Reset:
  - Stimulus: hold reset 3 cycles with both valids high.
  - Required: both readies 0, mem_we 0, no rsp_valid; first cycle after release, CPU is granted.
- CPU write/read:
  - Stimulus: CPU writes 0xDEADBEEF to 0x010, then reads 0x010 next cycle.
  - Required: cpu_rsp_valid pulses one cycle after the read with cpu_rdata = 0xDEADBEEF; dma_rsp_valid stays 0.
- Collision:
  - Stimulus: both request reads in the same cycle (CPU 0x004, DMA 0x008, preloaded 0x11 / 0x22).
  - Required: CPU gets 0x11 at cycle+1; DMA is accepted at cycle+1 and gets 0x22 at cycle+2.
- Interleave:
  - Stimulus: DMA streams 4 writes to 0x100..0x10C while the CPU is idle.
  - Required: one accept per cycle; a subsequent CPU read of 0x108 returns the third DMA word.
- Aging (macro on, DMA_MAX_WAIT = 8):
  - Stimulus: CPU valid continuously high, DMA read pending.
  - Required: DMA accepted exactly 8 cycles after it is raised; cpu_req_ready is low that single cycle.
  - With the macro off, the DMA never accepts over 100 cycles.
- Reset mid-read:
  - Stimulus: assert reset the cycle after a granted CPU read.
  - Required: cpu_rsp_valid stays 0 and rsp_owner returns to NONE.
